// File: rtl/apb_led_sequencer.sv
// APB3 slave LED sequencer: steps o_led through a pattern table at a programmable rate,
// in loop or one-shot mode, and shows a manual value while idle.
module apb_led_sequencer #(
  parameter int NUM_STEPS  = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic        io_systemClk,
  input  logic        io_systemReset,
  input  logic [15:0] io_apbSlave_0_PADDR,
  input  logic        io_apbSlave_0_PSEL,
  input  logic        io_apbSlave_0_PENABLE,
  input  logic        io_apbSlave_0_PWRITE,
  input  logic [31:0] io_apbSlave_0_PWDATA,
  output logic [31:0] io_apbSlave_0_PRDATA,
  output logic        io_apbSlave_0_PREADY,
  output logic        io_apbSlave_0_PSLVERROR,
  output logic [7:0]  o_led
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_STATUS   = 3'd2;
  localparam logic [2:0] A_MANUAL   = 3'd3;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            led_q, led_d;
  logic                  en_q, en_d;
  logic                  oneshot_q, oneshot_d;
  logic [2:0]            last_q, last_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  done_q, done_d;
  logic [7:0]            manual_q, manual_d;
  logic [7:0]            pattern_q [NUM_STEPS];
  logic [7:0]            pattern_d [NUM_STEPS];
  logic [31:0]           prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic [3:0]  addr;
  logic        setup, access, wr, mapped, busy, stop, done_set;
  logic [31:0] rd_data;
  logic [31:0] wdata;
  logic        unused_bits;

  assign addr   = io_apbSlave_0_PADDR[5:2];
  assign wdata  = io_apbSlave_0_PWDATA;
  assign setup  = io_apbSlave_0_PSEL & ~io_apbSlave_0_PENABLE;
  assign access = io_apbSlave_0_PSEL & io_apbSlave_0_PENABLE;
  assign wr     = access & io_apbSlave_0_PWRITE & mapped;
  assign busy   = (state_q == ST_RUN);
  assign stop   = wr & ~addr[3] & (addr[2:0] == A_CTRL) & ~wdata[0];

  assign unused_bits = ^{io_apbSlave_0_PADDR[15:6], io_apbSlave_0_PADDR[1:0], wdata[31:24]};

  always_comb begin
    rd_data = '0;
    mapped  = 1'b1;
    if (addr[3]) begin
      rd_data[7:0] = pattern_q[addr[2:0]];
    end else begin
      case (addr[2:0])
        A_CTRL:     rd_data = {25'd0, last_q, 2'd0, oneshot_q, en_q};
        A_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale_q;
        A_STATUS:   rd_data = {23'd0, done_q, 1'b0, idx_q, 3'd0, busy};
        A_MANUAL:   rd_data[7:0] = manual_q;
        default:    mapped = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    led_d      = led_q;
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    last_d     = last_q;
    prescale_d = prescale_q;
    done_d     = done_q;
    manual_d   = manual_q;
    pattern_d  = pattern_q;
    done_set   = 1'b0;
    prdata_d   = setup ? rd_data : prdata_q;
    pslverr_d  = setup & ~mapped;

    if (wr) begin
      if (addr[3]) begin
        pattern_d[addr[2:0]] = wdata[7:0];
      end else begin
        case (addr[2:0])
          A_CTRL: begin
            en_d      = wdata[0];
            oneshot_d = wdata[1];
            last_d    = wdata[6:4];
          end
          A_PRESCALE: prescale_d = wdata[PRESCALE_W-1:0];
          A_STATUS:   if (wdata[8]) done_d = 1'b0;
          A_MANUAL:   manual_d = wdata[7:0];
          default:    ;
        endcase
      end
    end

    // A stop write outranks a coincident step/DONE event, so DONE never sets on it.
    case (state_q)
      ST_IDLE: begin
        led_d = manual_q;
        cnt_d = '0;
        idx_d = '0;
        if (en_q && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        led_d = pattern_q[idx_q];
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q >= prescale_q) begin
          cnt_d = '0;
          if (idx_q < last_q) begin
            idx_d = idx_q + 3'd1;
          end else if (!oneshot_q) begin
            idx_d = '0;
          end else begin
            state_d  = ST_DONE;
            done_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (en_q) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_set) begin
      done_d = 1'b1;
      en_d   = 1'b0;
    end
  end

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      led_q      <= '0;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      last_q     <= '0;
      prescale_q <= '0;
      done_q     <= 1'b0;
      manual_q   <= '0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_STEPS; i++) pattern_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      last_q     <= last_d;
      prescale_q <= prescale_d;
      done_q     <= done_d;
      manual_q   <= manual_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      pattern_q  <= pattern_d;
    end
  end

  assign io_apbSlave_0_PRDATA    = prdata_q;
  assign io_apbSlave_0_PREADY    = access & ~io_systemReset;
  assign io_apbSlave_0_PSLVERROR = pslverr_q & access;
  assign o_led                   = led_q;

endmodule

// File: tb/tb_apb_led_sequencer.sv
module tb_apb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  led;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] R_CTRL = 16'h00, R_PRE = 16'h04, R_STAT = 16'h08, R_MAN = 16'h0C;

  always #5 clk = ~clk;

  apb_led_sequencer #(.NUM_STEPS(8), .PRESCALE_W(24)) dut (
    .io_systemClk           (clk),
    .io_systemReset         (rst),
    .io_apbSlave_0_PADDR    (paddr),
    .io_apbSlave_0_PSEL     (psel),
    .io_apbSlave_0_PENABLE  (penable),
    .io_apbSlave_0_PWRITE   (pwrite),
    .io_apbSlave_0_PWDATA   (pwdata),
    .io_apbSlave_0_PRDATA   (prdata),
    .io_apbSlave_0_PREADY   (pready),
    .io_apbSlave_0_PSLVERROR(pslverr),
    .o_led                  (led)
  );

  // Expected LED after the n-th edge following the edge that first sees EN=1.
  function automatic logic [7:0] exp_led(input int n, input int p, input int l, input bit os,
                                          input logic [7:0] pat [8], input logic [7:0] man);
    int steps;
    if (n == 0) return man;
    steps = (n - 1) / (p + 1);
    if (os && steps > l) return pat[l];
    return pat[steps % (l + 1)];
  endfunction

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic rdy, output logic err);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    #1 rdy = pready; err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic r, e;
    apb_write(a, d, r, e);
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic rdy, output logic err);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    #1 d = prdata; rdy = pready; err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic cfg(input int p, input logic [7:0] pat [8], input logic [7:0] man);
    wr(R_CTRL, 32'h0);
    wr(R_MAN, {24'h0, man});
    wr(R_PRE, 32'(p));
    for (int i = 0; i < 8; i++) wr(16'(16'h20 + 4 * i), {24'h0, pat[i]});
  endtask

  task automatic test_reset;
    rst = 1'b1; paddr = R_MAN; pwdata = 32'hFF; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    #1;
    n_cmp++; if (pready !== 1'b0) begin n_err++; $display("FAIL reset_pready got=%b exp=0", pready); end
    @(posedge clk); #1;
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led got=%h exp=00", led); end
    n_cmp++; if (prdata !== 32'h0) begin n_err++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    n_cmp++; if (pslverr !== 1'b0) begin n_err++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
    begin
      logic [31:0] d; logic r, e;
      apb_read(R_MAN, d, r, e);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_write_ignored got=%h exp=0", d); end
    end
  endtask

  task automatic test_regs;
    logic [31:0] d, v, exp; logic r, e;
    logic [3:0] offs [12];
    offs = '{4'h0, 4'h1, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h2};
    for (int k = 0; k < 2; k++) begin
      foreach (offs[i]) begin
        logic [15:0] a;
        a = {6'($urandom), offs[i], 2'($urandom)};
        v = $urandom;
        if (offs[i] == 4'h0) v[0] = 1'b0;
        apb_write(a, v, r, e);
        apb_read(a, d, r, e);
        case (offs[i])
          4'h0:    exp = v & 32'h72;
          4'h1:    exp = v & 32'hFF_FFFF;
          4'h2:    exp = 32'h0;
          default: exp = v & 32'hFF;
        endcase
        n_cmp++;
        if (d !== exp || e !== 1'b0 || r !== 1'b1)
          begin n_err++; $display("FAIL reg_rw off=%h got=%h err=%b rdy=%b exp=%h", offs[i], d, e, r, exp); end
      end
    end
  endtask

  task automatic test_manual;
    logic [7:0] m;
    for (int k = 0; k < 3; k++) begin
      m = 8'($urandom);
      wr(R_MAN, {24'h0, m});
      @(posedge clk); #1;
      n_cmp++; if (led !== m) begin n_err++; $display("FAIL manual_led got=%h exp=%h", led, m); end
    end
  endtask

  task automatic run_seq(input int p, input int l, input bit os, input logic [7:0] pat [8], input logic [7:0] man);
    logic [31:0] d; logic r, e;
    int ncyc;
    ncyc = os ? (p + 1) * (l + 1) + 4 : 2 * (p + 1) * (l + 1) + 2;
    cfg(p, pat, man);
    wr(R_CTRL, 32'((l << 4) | (int'(os) << 1) | 1));
    for (int n = 0; n <= ncyc; n++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (led !== exp_led(n, p, l, os, pat, man))
        begin n_err++; $display("FAIL seq_led p=%0d l=%0d os=%0d n=%0d got=%h exp=%h", p, l, os, n, led, exp_led(n, p, l, os, pat, man)); end
    end
    apb_read(R_STAT, d, r, e);
    if (os) begin
      n_cmp++; if ((d & 32'h101) !== 32'h100) begin n_err++; $display("FAIL oneshot_status got=%h exp_done_notbusy", d); end
      apb_read(R_CTRL, d, r, e);
      n_cmp++; if (d !== 32'((l << 4) | 2)) begin n_err++; $display("FAIL oneshot_ctrl got=%h exp=%h", d, 32'((l << 4) | 2)); end
      wr(R_STAT, 32'h100);
      apb_read(R_STAT, d, r, e);
      n_cmp++; if ((d & 32'h101) !== 32'h0) begin n_err++; $display("FAIL done_w1c got=%h exp_done=0", d); end
      n_cmp++; if (led !== pat[l]) begin n_err++; $display("FAIL done_hold got=%h exp=%h", led, pat[l]); end
    end else begin
      n_cmp++; if (d[0] !== 1'b1 || d[8] !== 1'b0) begin n_err++; $display("FAIL loop_status got=%h exp_busy=1", d); end
      apb_read(R_CTRL, d, r, e);
      n_cmp++; if (d !== 32'((l << 4) | 1)) begin n_err++; $display("FAIL loop_ctrl got=%h exp=%h", d, 32'((l << 4) | 1)); end
    end
  endtask

  task automatic test_sequences;
    logic [7:0] pat [8];
    pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    run_seq(3, 3, 1'b0, pat, 8'h5A);
    pat = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_seq(0, 2, 1'b1, pat, 8'h3C);
    for (int k = 0; k < 6; k++) begin
      foreach (pat[i]) pat[i] = 8'($urandom);
      run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), 1'($urandom), pat, 8'($urandom));
    end
  endtask

  task automatic test_stop;
    logic [7:0] pat [8]; logic [31:0] d; logic r, e;
    foreach (pat[i]) pat[i] = 8'($urandom);
    cfg(3, pat, 8'h81);
    wr(R_CTRL, 32'h71);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (led !== pat[2]) begin n_err++; $display("FAIL stop_at_step2 got=%h exp=%h", led, pat[2]); end
    wr(R_CTRL, 32'h0);
    @(posedge clk); #1;
    n_cmp++; if (led !== 8'h81) begin n_err++; $display("FAIL stop_manual got=%h exp=81", led); end
    apb_read(R_STAT, d, r, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL stop_status got=%h exp=0", d); end
  endtask

  task automatic test_error;
    logic [31:0] d; logic r, e;
    wr(R_CTRL, 32'h52);
    wr(R_PRE, 32'h1234);
    wr(R_MAN, 32'hC3);
    apb_read(16'h10, d, r, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0 || r !== 1'b1) begin n_err++; $display("FAIL err_read err=%b data=%h rdy=%b exp=1/0/1", e, d, r); end
    n_cmp++; if (pslverr !== 1'b0) begin n_err++; $display("FAIL err_oneshot got=%b exp=0", pslverr); end
    apb_write(16'h14, 32'hFFFF_FFFF, r, e);
    n_cmp++; if (e !== 1'b1 || r !== 1'b1) begin n_err++; $display("FAIL err_write err=%b rdy=%b exp=1/1", e, r); end
    apb_read(R_CTRL, d, r, e);
    n_cmp++; if (d !== 32'h52 || e !== 1'b0) begin n_err++; $display("FAIL err_ctrl_kept got=%h err=%b exp=52/0", d, e); end
    apb_read(R_PRE, d, r, e);
    n_cmp++; if (d !== 32'h1234) begin n_err++; $display("FAIL err_pre_kept got=%h exp=1234", d); end
    apb_read(R_MAN, d, r, e);
    n_cmp++; if (d !== 32'hC3) begin n_err++; $display("FAIL err_man_kept got=%h exp=c3", d); end
  endtask

  task automatic test_shrink;
    logic [7:0] pat [8]; logic [7:0] exp [6];
    pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    exp = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04};
    cfg(20, pat, 8'h00);
    wr(R_CTRL, 32'h71);
    repeat (10) @(posedge clk);
    #1;
    wr(R_PRE, 32'd2);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_cmp++; if (led !== exp[i]) begin n_err++; $display("FAIL shrink_led i=%0d got=%h exp=%h", i, led, exp[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pat [8]; logic [31:0] d; logic r, e;
    logic [15:0] addrs [12];
    addrs = '{R_CTRL, R_PRE, R_STAT, R_MAN, 16'h20, 16'h24, 16'h28, 16'h2C, 16'h30, 16'h34, 16'h38, 16'h3C};
    foreach (pat[i]) pat[i] = 8'($urandom_range(1, 255));
    cfg(1, pat, 8'h00);
    wr(R_CTRL, 32'h71);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (led !== pat[3]) begin n_err++; $display("FAIL rstmid_step3 got=%h exp=%h", led, pat[3]); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL rstmid_led got=%h exp=00", led); end
    foreach (addrs[i]) begin
      apb_read(addrs[i], d, r, e);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rstmid_reg a=%h got=%h exp=0", addrs[i], d); end
    end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL rstmid_idle_led got=%h exp=00", led); end
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    @(posedge clk); #1;
    test_reset;
    test_regs;
    test_manual;
    test_sequences;
    test_stop;
    test_error;
    test_shrink;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_led_sequencer.md
APB_LED_SEQUENCER -- requirements
Module: apb_led_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 8, pattern table depth (fixed 8 in this revision).
REQ-002 SHALL have parameter PRESCALE_W, default 24, prescaler register width.
REQ-003 SHALL have port io_systemClk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port io_systemReset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port io_apbSlave_0_PADDR, input, 16, APB3 byte address; only [5:2] decoded, [1:0] ignored.
REQ-006 SHALL have ports io_apbSlave_0_PSEL, io_apbSlave_0_PENABLE and io_apbSlave_0_PWRITE, each input, 1, APB3 control.
REQ-007 SHALL have port io_apbSlave_0_PWDATA, input, 32, write data.
REQ-008 SHALL have port io_apbSlave_0_PRDATA, output, 32, read data.
REQ-009 SHALL have port io_apbSlave_0_PREADY, output, 1, transfer complete.
REQ-010 SHALL have port io_apbSlave_0_PSLVERROR, output, 1, unmapped-access error.
REQ-011 SHALL have port o_led, output, 8, registered LED drive.

Function
REQ-012 SHALL implement this register map (byte offsets):
- 0x00 CTRL RW: [0] EN, [1] ONESHOT, [6:4] LAST (final step index).
- 0x04 PRESCALE RW: [23:0] cycles per step minus 1.
- 0x08 STATUS: [0] BUSY RO, [6:4] IDX RO, [8] DONE W1C.
- 0x0C MANUAL RW: [7:0] LED value when idle.
- 0x20..0x3C PATTERN[0..7] RW: [7:0].
- Unused register bits read 0.
REQ-013 SHALL use zero-wait APB3 transfers: PREADY = PSEL & PENABLE; no wait states.
REQ-014 SHALL register PRDATA in the setup cycle (PSEL & !PENABLE); PRDATA SHALL be valid throughout the access cycle.
REQ-015 SHALL commit a write on the access cycle (PSEL & PENABLE & PWRITE), visible the next cycle.
REQ-016 SHALL, on an unmapped offset, assert PSLVERROR in the access cycle only, return PRDATA = 0 and ignore write data.
REQ-017 SHALL implement FSM states IDLE, RUN and DONE, with a 24-bit cycle counter CNT and a 3-bit step index IDX.
REQ-018 SHALL, in IDLE, drive o_led <= MANUAL each cycle, hold BUSY = 0 and move to RUN when EN = 1 (CNT = 0, IDX = 0).
REQ-019 SHALL, in RUN, drive o_led <= PATTERN[IDX] each cycle (first pattern appears the cycle after entry), hold BUSY = 1 and increment CNT.
REQ-020 SHALL, in RUN when CNT >= PRESCALE, clear CNT and:
- if IDX < LAST: increment IDX;
- if IDX >= LAST and ONESHOT = 0: set IDX = 0;
- if IDX >= LAST and ONESHOT = 1: go to DONE, set DONE and clear EN.
REQ-021 SHALL hold o_led at its last value in DONE and move to RUN with IDX = 0 and CNT = 0 on a write with EN = 1.
REQ-022 SHALL, when EN is written 0 in RUN or DONE, go to IDLE next cycle with CNT and IDX cleared; this SHALL take priority over a simultaneous step or DONE event, and DONE SHALL NOT set.
REQ-023 SHALL let writes to PRESCALE, LAST or PATTERN during RUN take effect at the next compare or output update without restarting the sequence; the >= compares SHALL keep a shrunken value from overrunning.
REQ-024 SHALL give hardware set of DONE priority over a simultaneous W1C clear.
REQ-025 SHALL treat PRESCALE = 0 as one step per cycle.

Reset
REQ-026 SHALL, on io_systemReset = 1 at a clock edge, clear all registers, CNT, IDX, o_led, PRDATA and PSLVERROR to 0, set the FSM to IDLE and abort any transfer or sequence.
REQ-027 SHALL, with reset held, produce PREADY = 0 and ignore APB writes.

Verification
REQ-028 SHALL cover loop mode:
- Stimulus: PATTERN[0..3] = 01, 02, 04, 08; PRESCALE = 3; CTRL = 0x31.
- Response: o_led steps 01, 02, 04, 08, 01 with 4 cycles per step; BUSY = 1.
REQ-029 SHALL cover oneshot mode:
- Stimulus: CTRL = 0x23; PRESCALE = 0; PATTERN[0..2] = AA, 55, FF.
- Response: o_led AA, 55, FF, then holds FF; DONE = 1, EN reads 0; W1C 0x100 clears DONE.
REQ-030 SHALL cover stop mid-run:
- Stimulus: write CTRL = 0 during step 2, MANUAL = 0x81.
- Response: o_led = 81 the cycle after state reaches IDLE; STATUS = 0.
REQ-031 SHALL cover the error path:
- Stimulus: read 0x10 and write 0x14.
- Response: PSLVERROR = 1 for one access cycle, PRDATA = 0, no register change; PREADY = 1 on every access cycle.
REQ-032 SHALL cover reset mid-sequence:
- Stimulus: assert io_systemReset for 1 cycle while RUN at IDX = 3.
- Response: o_led = 0, all registers read 0, FSM IDLE.
REQ-033 SHALL cover a shrinking register write:
- Stimulus: write PRESCALE = 2 while CNT = 10.
- Response: step advances on the next cycle.
